// File: rtl/mesi_isc_mon_pkg.sv
// Shared types for the MESI ISC bus monitor: bus command encodings, the
// handshake tracker state, error-bit positions and small command classifiers.
package mesi_isc_mon_pkg;

   localparam int CMD_W = 3;
   localparam int ERR_W = 8;

   // Error flag bit positions in err_o
   localparam int ERR_STABLE_M = 0;
   localparam int ERR_SPUR_MACK = 1;
   localparam int ERR_TO_M = 2;
   localparam int ERR_STABLE_C = 3;
   localparam int ERR_SPUR_CACK = 4;
   localparam int ERR_TO_C = 5;
   localparam int ERR_OVF = 6;
   localparam int ERR_UNF = 7;

   typedef enum logic [CMD_W-1:0] {
      MBUS_NOP      = 3'd0,
      MBUS_WR       = 3'd1,
      MBUS_RD       = 3'd2,
      MBUS_WR_BROAD = 3'd3,
      MBUS_RD_BROAD = 3'd4
   } mbus_cmd_e;

   typedef enum logic [CMD_W-1:0] {
      CBUS_NOP      = 3'd0,
      CBUS_WR_SNOOP = 3'd1,
      CBUS_RD_SNOOP = 3'd2,
      CBUS_EN_WR    = 3'd3,
      CBUS_EN_RD    = 3'd4
   } cbus_cmd_e;

   typedef enum logic {
      TRK_IDLE = 1'b0,
      TRK_PEND = 1'b1
   } trk_state_e;

   // mbus request that allocates a broadcast slot in the ISC
   function automatic logic is_broad(input logic [CMD_W-1:0] c);
      return (c == MBUS_WR_BROAD) || (c == MBUS_RD_BROAD);
   endfunction

   // cbus enable that retires a broadcast slot in the ISC
   function automatic logic is_en(input logic [CMD_W-1:0] c);
      return (c == CBUS_EN_WR) || (c == CBUS_EN_RD);
   endfunction

   // cbus snoop command that must finish before any enable goes out
   function automatic logic is_snoop(input logic [CMD_W-1:0] c);
      return (c == CBUS_WR_SNOOP) || (c == CBUS_RD_SNOOP);
   endfunction

endpackage

// File: rtl/mesi_isc_hs_tracker.sv
// One request/ack handshake tracker: follows a single command channel from
// request to ack, holds the command/address seen at request time, and flags
// instability, acks with nothing outstanding, and requests that wait too long.
// Error outputs are combinational for the current edge; the caller registers them.
module mesi_isc_hs_tracker
   import mesi_isc_mon_pkg::*;
#(
   parameter int CMD_W      = 3,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CMD_W-1:0]      cmd,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  ack,
   output logic [CMD_W-1:0]      pend_cmd,
   output logic                  err_stable,
   output logic                  err_spur,
   output logic                  err_to
);

   localparam int TW = $clog2(TIMEOUT + 1);

   trk_state_e            state;
   logic [TW-1:0]         wait_cnt;
   logic [CMD_W-1:0]      lat_cmd;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic                  req;
   logic                  start;
   logic                  hit_to;

   assign req    = (cmd != '0);
   // a request not acked on its first edge opens a pending handshake
   assign start  = (state == TRK_IDLE) && req && !ack;
   // wait_cnt counts unacked edges so far; this edge would be number TIMEOUT
   assign hit_to = (wait_cnt == TW'(TIMEOUT - 1));

   assign pend_cmd = (state == TRK_PEND) ? lat_cmd : '0;

   // Classify the current edge against the tracker state
   always_comb begin
      err_stable = 1'b0;
      err_spur   = 1'b0;
      err_to     = 1'b0;
      if (state == TRK_PEND) begin
         err_stable = (cmd != lat_cmd) || (addr != lat_addr);
         err_to     = !ack && hit_to;
      end else begin
         err_spur   = !req && ack;
      end
   end

   // Handshake FSM and wait timer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= TRK_IDLE;
         wait_cnt <= '0;
      end else if (state == TRK_IDLE) begin
         if (start) begin
            state    <= TRK_PEND;
            wait_cnt <= TW'(1);
         end
      end else begin
         if (ack || hit_to) begin
            state    <= TRK_IDLE;
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + TW'(1);
         end
      end
   end

   // Capture the command and address presented when the handshake opens
   always_ff @(posedge clk) begin
      if (start) begin
         lat_cmd  <= cmd;
         lat_addr <= addr;
      end
   end

endmodule

// File: rtl/mesi_isc_bus_monitor.sv
// Protocol monitor for the MESI intersection controller. One handshake tracker
// per CPU on each of mbus and cbus, plus broadcast-slot accounting, a
// completed-broadcast counter and a sticky error latch with first-offender index.
module mesi_isc_bus_monitor
   import mesi_isc_mon_pkg::*;
#(
   parameter int NUM_CPU    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 64,
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [CMD_W*NUM_CPU-1:0]         mbus_cmd_i,
   input  logic [ADDR_WIDTH*NUM_CPU-1:0]    mbus_addr_i,
   input  logic [NUM_CPU-1:0]               mbus_ack_o_i,
   input  logic [CMD_W*NUM_CPU-1:0]         cbus_cmd_o_i,
   input  logic [ADDR_WIDTH-1:0]            cbus_addr_o_i,
   input  logic [NUM_CPU-1:0]               cbus_ack_i,
   input  logic                             err_clr_i,
   output logic [ERR_W-1:0]                 err_o,
   output logic [$clog2(NUM_CPU)-1:0]       err_cpu_o,
   output logic                             err_pulse_o,
   output logic [CNT_WIDTH-1:0]             bcast_cnt_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  outst_o
);

   localparam int CW = $clog2(NUM_CPU);
   localparam int OW = $clog2(FIFO_DEPTH + 1);
   localparam int NW = $clog2(NUM_CPU + 1);
   localparam int SW = OW + NW + 2;

   logic [NUM_CPU-1:0] m_stable, m_spur, m_to;
   logic [NUM_CPU-1:0] c_stable, c_spur, c_to;
   logic [NUM_CPU-1:0] snoop_pend, en_now, snoop_err;
   logic [NUM_CPU-1:0] broad_ack, en_ack;

   logic [NW-1:0]          n_inc_p0, n_dec_p0;
   logic signed [SW-1:0]   outst_sum_p0;
   logic                   ovf_p0, unf_p0;
   logic [OW-1:0]          outst_nxt_p0;
   logic [CNT_WIDTH-1:0]   bcast_nxt_p0;
   logic [NUM_CPU-1:0]     cpu_err_p0;
   logic [ERR_W-1:0]       new_err_p0;
   logic [CW-1:0]          first_cpu_p0;

   // Add a small increment to the broadcast counter, sticking at all-ones
   function automatic logic [CNT_WIDTH-1:0] sat_add_cnt(
      input logic [CNT_WIDTH-1:0] a,
      input logic [NW-1:0]        b
   );
      logic [CNT_WIDTH:0] s;
      s = {1'b0, a} + (CNT_WIDTH + 1)'(b);
      return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
   endfunction

   // Limit the signed occupancy estimate to the legal range 0..FIFO_DEPTH
   function automatic logic [OW-1:0] clamp_outst(input logic signed [SW-1:0] s);
      if (s > $signed(SW'(FIFO_DEPTH)))
         return OW'(FIFO_DEPTH);
      else if (s < 0)
         return '0;
      else
         return s[OW-1:0];
   endfunction

   for (genvar i = 0; i < NUM_CPU; i++) begin : g_cpu
      logic [CMD_W-1:0]   m_cmd;
      logic [CMD_W-1:0]   c_cmd;
      logic [CMD_W-1:0]   c_pend_cmd;
      logic [CMD_W-1:0]   m_pend_cmd_unused;
      logic [NUM_CPU-1:0] others;

      assign m_cmd  = mbus_cmd_i[CMD_W*i +: CMD_W];
      assign c_cmd  = cbus_cmd_o_i[CMD_W*i +: CMD_W];
      assign others = ~(NUM_CPU'(1) << i);

      mesi_isc_hs_tracker #(
         .CMD_W      (CMD_W),
         .ADDR_WIDTH (ADDR_WIDTH),
         .TIMEOUT    (TIMEOUT)
      ) u_mbus_trk (
         .clk        (clk),
         .rst        (rst),
         .cmd        (m_cmd),
         .addr       (mbus_addr_i[ADDR_WIDTH*i +: ADDR_WIDTH]),
         .ack        (mbus_ack_o_i[i]),
         .pend_cmd   (m_pend_cmd_unused),
         .err_stable (m_stable[i]),
         .err_spur   (m_spur[i]),
         .err_to     (m_to[i])
      );

      // every cbus tracker watches the shared broadcast address
      mesi_isc_hs_tracker #(
         .CMD_W      (CMD_W),
         .ADDR_WIDTH (ADDR_WIDTH),
         .TIMEOUT    (TIMEOUT)
      ) u_cbus_trk (
         .clk        (clk),
         .rst        (rst),
         .cmd        (c_cmd),
         .addr       (cbus_addr_o_i),
         .ack        (cbus_ack_i[i]),
         .pend_cmd   (c_pend_cmd),
         .err_stable (c_stable[i]),
         .err_spur   (c_spur[i]),
         .err_to     (c_to[i])
      );

      assign broad_ack[i]  = mbus_ack_o_i[i] && is_broad(m_cmd);
      assign en_ack[i]     = cbus_ack_i[i] && is_en(c_cmd);
      assign snoop_pend[i] = is_snoop(c_pend_cmd);
      assign en_now[i]     = is_en(c_cmd);
      // an enable must not overtake a snoop still outstanding on another CPU
      assign snoop_err[i]  = en_now[i] && |(snoop_pend & others);
   end

   // Count broadcast allocations and retirements acked on this edge
   always_comb begin
      n_inc_p0 = '0;
      n_dec_p0 = '0;
      for (int i = 0; i < NUM_CPU; i++) begin
         n_inc_p0 = n_inc_p0 + NW'(broad_ack[i]);
         n_dec_p0 = n_dec_p0 + NW'(en_ack[i]);
      end
   end

   // Occupancy update with overflow/underflow detection
   always_comb begin
      outst_sum_p0 = $signed(SW'(outst_o)) + $signed(SW'(n_inc_p0))
                   - $signed(SW'(n_dec_p0));
      ovf_p0       = outst_sum_p0 > $signed(SW'(FIFO_DEPTH));
      unf_p0       = outst_sum_p0 < 0;
      outst_nxt_p0 = clamp_outst(outst_sum_p0);
      bcast_nxt_p0 = sat_add_cnt(bcast_cnt_o, n_dec_p0);
   end

   // Gather this edge's violations and find the lowest offending CPU
   always_comb begin
      cpu_err_p0 = m_stable | m_spur | m_to | c_stable | c_spur | c_to | snoop_err;
      new_err_p0                = '0;
      new_err_p0[ERR_STABLE_M]  = |m_stable;
      new_err_p0[ERR_SPUR_MACK] = |m_spur;
      new_err_p0[ERR_TO_M]      = |m_to;
      new_err_p0[ERR_STABLE_C]  = |c_stable | |snoop_err;
      new_err_p0[ERR_SPUR_CACK] = |c_spur;
      new_err_p0[ERR_TO_C]      = |c_to;
      new_err_p0[ERR_OVF]       = ovf_p0;
      new_err_p0[ERR_UNF]       = unf_p0;
      first_cpu_p0 = '0;
      for (int i = NUM_CPU - 1; i >= 0; i--) begin
         if (cpu_err_p0[i])
            first_cpu_p0 = CW'(i);
      end
   end

   // ---- stage p0 -> outputs: counters, sticky error latch, new-error pulse ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         outst_o     <= '0;
         bcast_cnt_o <= '0;
         err_o       <= '0;
         err_cpu_o   <= '0;
         err_pulse_o <= 1'b0;
      end else begin
         outst_o     <= outst_nxt_p0;
         bcast_cnt_o <= bcast_nxt_p0;
         if (err_clr_i) begin
            err_o       <= '0;
            err_cpu_o   <= '0;
            err_pulse_o <= 1'b0;
         end else begin
            err_o       <= err_o | new_err_p0;
            err_pulse_o <= |(new_err_p0 & ~err_o);
            // only the first error cycle after a clear names the offender
            if ((err_o == '0) && (new_err_p0 != '0))
               err_cpu_o <= first_cpu_p0;
         end
      end
   end

endmodule

// File: tb/tb_mesi_isc_bus_monitor.sv
// Directed bench for mesi_isc_bus_monitor. A transaction-level model tracks
// each channel as "open since cycle N with cmd/addr", and a negedge process
// compares every output against it each cycle; literal checks pin key points.
module tb_mesi_isc_bus_monitor;

   localparam int NUM_CPU    = 4;
   localparam int AW         = 32;
   localparam int TIMEOUT    = 64;
   localparam int FIFO_DEPTH = 2;
   localparam int CNT_WIDTH  = 16;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [3*NUM_CPU-1:0]    mbus_cmd;
   logic [AW*NUM_CPU-1:0]   mbus_addr;
   logic [NUM_CPU-1:0]      mbus_ack;
   logic [3*NUM_CPU-1:0]    cbus_cmd;
   logic [AW-1:0]           cbus_addr;
   logic [NUM_CPU-1:0]      cbus_ack;
   logic                    err_clr;
   logic [7:0]              err_o;
   logic [1:0]              err_cpu_o;
   logic                    err_pulse_o;
   logic [CNT_WIDTH-1:0]    bcast_cnt_o;
   logic [1:0]              outst_o;

   int n_vec = 0;
   int n_mis = 0;
   bit run = 0;

   // model state: index 0 = mbus, 1 = cbus
   int         open_m [2][NUM_CPU];
   int         cmd_m  [2][NUM_CPU];
   logic [AW-1:0] addr_m [2][NUM_CPU];
   int         since_m[2][NUM_CPU];
   int         cyc_m;
   int         exp_outst, exp_bcast, exp_cpu;
   logic [7:0] exp_err;
   bit         exp_pulse;

   mesi_isc_bus_monitor #(
      .NUM_CPU    (NUM_CPU),
      .ADDR_WIDTH (AW),
      .TIMEOUT    (TIMEOUT),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mbus_cmd_i    (mbus_cmd),
      .mbus_addr_i   (mbus_addr),
      .mbus_ack_o_i  (mbus_ack),
      .cbus_cmd_o_i  (cbus_cmd),
      .cbus_addr_o_i (cbus_addr),
      .cbus_ack_i    (cbus_ack),
      .err_clr_i     (err_clr),
      .err_o         (err_o),
      .err_cpu_o     (err_cpu_o),
      .err_pulse_o   (err_pulse_o),
      .bcast_cnt_o   (bcast_cnt_o),
      .outst_o       (outst_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < NUM_CPU; i++) begin
            open_m[b][i] = 0; cmd_m[b][i] = 0; addr_m[b][i] = '0; since_m[b][i] = 0;
         end
      cyc_m = 0; exp_outst = 0; exp_bcast = 0; exp_cpu = 0; exp_err = '0; exp_pulse = 0;
   endtask

   // What the monitor must conclude from the inputs seen at one rising edge
   task automatic model_step();
      logic [7:0]         ne;
      bit [NUM_CPU-1:0]   flagged;
      bit                 snoop_open[NUM_CPU];
      int                 inc, dec, s, c, cc;
      logic [AW-1:0]      a;
      bit                 k;
      ne = '0; flagged = '0; inc = 0; dec = 0;
      cyc_m++;
      for (int i = 0; i < NUM_CPU; i++)
         snoop_open[i] = open_m[1][i] != 0 && (cmd_m[1][i] == 1 || cmd_m[1][i] == 2);
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < NUM_CPU; i++) begin
            if (b == 0) begin
               c = int'(mbus_cmd[3*i +: 3]); a = mbus_addr[AW*i +: AW]; k = mbus_ack[i];
            end else begin
               c = int'(cbus_cmd[3*i +: 3]); a = cbus_addr; k = cbus_ack[i];
            end
            if (open_m[b][i] != 0) begin
               if (c != cmd_m[b][i] || a != addr_m[b][i]) begin ne[3*b] = 1; flagged[i] = 1; end
               if (k) open_m[b][i] = 0;
               else if (cyc_m - since_m[b][i] + 1 == TIMEOUT) begin
                  ne[3*b+2] = 1; flagged[i] = 1; open_m[b][i] = 0;
               end
            end else if (c != 0 && !k) begin
               open_m[b][i] = 1; cmd_m[b][i] = c; addr_m[b][i] = a; since_m[b][i] = cyc_m;
            end else if (c == 0 && k) begin
               ne[3*b+1] = 1; flagged[i] = 1;
            end
            if (k && (c == 3 || c == 4)) begin
               if (b == 0) inc++; else dec++;
            end
         end
      end
      for (int i = 0; i < NUM_CPU; i++) begin
         cc = int'(cbus_cmd[3*i +: 3]);
         if (cc == 3 || cc == 4)
            for (int j = 0; j < NUM_CPU; j++)
               if (j != i && snoop_open[j]) begin ne[3] = 1; flagged[i] = 1; end
      end
      s = exp_outst + inc - dec;
      if (s > FIFO_DEPTH) begin ne[6] = 1; s = FIFO_DEPTH; end
      if (s < 0) begin ne[7] = 1; s = 0; end
      exp_outst = s;
      exp_bcast = exp_bcast + dec;
      if (exp_bcast > (1 << CNT_WIDTH) - 1) exp_bcast = (1 << CNT_WIDTH) - 1;
      if (err_clr) begin
         exp_err = '0; exp_cpu = 0; exp_pulse = 0;
      end else begin
         exp_pulse = (ne & ~exp_err) != '0;
         if (exp_err == '0 && ne != '0) begin
            exp_cpu = 0;
            for (int i = NUM_CPU - 1; i >= 0; i--) if (flagged[i]) exp_cpu = i;
         end
         exp_err = exp_err | ne;
      end
   endtask

   // Compare all outputs against the model once per cycle
   always @(negedge clk) begin
      if (run) begin
         check("cmp_err_o", 32'(err_o), 32'(exp_err));
         check("cmp_err_cpu_o", 32'(err_cpu_o), 32'(exp_cpu));
         check("cmp_err_pulse_o", 32'(err_pulse_o), 32'(exp_pulse));
         check("cmp_bcast_cnt_o", 32'(bcast_cnt_o), 32'(exp_bcast));
         check("cmp_outst_o", 32'(outst_o), 32'(exp_outst));
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         if (rst) model_step();
         @(negedge clk);
      end
   endtask

   task automatic idle_in();
      mbus_cmd = '0; mbus_addr = '0; mbus_ack = '0;
      cbus_cmd = '0; cbus_addr = '0; cbus_ack = '0; err_clr = 1'b0;
   endtask

   task automatic set_m(input int i, input int c, input logic [AW-1:0] a, input bit k);
      mbus_cmd[3*i +: 3] = 3'(c); mbus_addr[AW*i +: AW] = a; mbus_ack[i] = k;
   endtask

   task automatic set_c(input int i, input int c, input bit k);
      cbus_cmd[3*i +: 3] = 3'(c); cbus_ack[i] = k;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      idle_in();
      model_reset();
      repeat (3) @(negedge clk);
      run = 1;
      check("reset_err_o", 32'(err_o), 0);
      check("reset_outst_o", 32'(outst_o), 0);
      check("reset_bcast", 32'(bcast_cnt_o), 0);
      rst = 1'b1;
      tick(2);

      // 1: held WR_BROAD acked on 4th cycle, then EN_WR retires it
      set_m(1, 3, 32'h40, 0); tick(3);
      set_m(1, 3, 32'h40, 1); tick();
      check("t1_outst_after_broad", 32'(outst_o), 1);
      check("t1_no_err", 32'(err_o), 0);
      set_m(1, 0, '0, 0); cbus_addr = 32'h40; set_c(1, 3, 1); tick();
      check("t1_outst_after_en", 32'(outst_o), 0);
      check("t1_bcast", 32'(bcast_cnt_o), 1);
      set_c(1, 0, 0); tick();

      // 2: address moves while RD pending
      set_m(2, 2, 32'h10, 0); tick();
      set_m(2, 2, 32'h14, 0); tick();
      check("t2_err_o", 32'(err_o), 32'h01);
      check("t2_err_cpu", 32'(err_cpu_o), 2);
      check("t2_pulse_high", 32'(err_pulse_o), 1);
      set_m(2, 2, 32'h14, 1); tick();
      check("t2_pulse_one_cycle", 32'(err_pulse_o), 0);
      set_m(2, 0, '0, 0); err_clr = 1; tick(); err_clr = 0;
      check("t2_cleared", 32'(err_o), 0);

      // 3: spurious mbus ack, then clear; clear beats a same-cycle error
      mbus_ack[3] = 1; tick();
      check("t3_err_o", 32'(err_o), 32'h02);
      check("t3_err_cpu", 32'(err_cpu_o), 3);
      mbus_ack[3] = 0; err_clr = 1; tick();
      check("t3_cleared", 32'(err_o), 0);
      mbus_ack[3] = 1; tick();
      check("t3_clr_wins", 32'(err_o), 0);
      check("t3_clr_wins_pulse", 32'(err_pulse_o), 0);
      mbus_ack[3] = 0; err_clr = 0; tick();

      // 4: RD_SNOOP never acked on CPU0
      cbus_addr = 32'h80; set_c(0, 2, 0); tick(63);
      check("t4_before_timeout", 32'(err_o), 0);
      tick();
      check("t4_timeout", 32'(err_o), 32'h20);
      check("t4_err_cpu", 32'(err_cpu_o), 0);
      set_c(0, 0, 1); tick();
      check("t4_idle_after_to", 32'(err_o), 32'h30);
      set_c(0, 0, 0); err_clr = 1; tick(); err_clr = 0;

      // 5: occupancy overflow, multi-ack retire, underflow, inc+dec net zero
      set_m(0, 3, 32'h100, 1); tick();
      check("t5_outst1", 32'(outst_o), 1);
      set_m(0, 0, '0, 0); set_m(1, 4, 32'h104, 1); tick();
      set_m(1, 0, '0, 0); set_m(2, 3, 32'h108, 1); tick();
      check("t5_ovf_err", 32'(err_o), 32'h40);
      check("t5_ovf_clamp", 32'(outst_o), 2);
      set_m(2, 0, '0, 0); set_c(0, 3, 1); set_c(1, 4, 1); tick();
      check("t5_two_en", 32'(outst_o), 0);
      check("t5_bcast3", 32'(bcast_cnt_o), 3);
      set_c(0, 0, 0); set_c(1, 0, 0); set_c(3, 4, 1); tick();
      check("t5_unf_err", 32'(err_o), 32'hC0);
      check("t5_unf_hold", 32'(outst_o), 0);
      check("t5_global_cpu", 32'(err_cpu_o), 0);
      set_c(3, 0, 0); err_clr = 1; tick(); err_clr = 0;
      set_m(0, 3, 32'h10C, 1); set_c(1, 3, 1); tick();
      check("t5_net_zero_err", 32'(err_o), 0);
      check("t5_net_zero_bcast", 32'(bcast_cnt_o), 5);
      set_m(0, 0, '0, 0); set_c(1, 0, 0); tick();

      // snoop ordering: enable on CPU2 while CPU1 snoop is open
      cbus_addr = 32'h200; set_c(1, 1, 0); tick();
      set_c(2, 4, 1); tick();
      check("snoop_order_err", 32'(err_o), 32'h88);
      check("snoop_order_cpu", 32'(err_cpu_o), 2);
      set_c(2, 0, 0); set_c(1, 1, 1); tick();
      set_c(1, 0, 0); tick();

      // 6: asynchronous reset mid-pending with errors latched
      set_m(3, 1, 32'h300, 0); tick();
      #2 rst = 1'b0;
      #1;
      check("t6_async_err", 32'(err_o), 0);
      check("t6_async_pulse", 32'(err_pulse_o), 0);
      check("t6_async_bcast", 32'(bcast_cnt_o), 0);
      model_reset();
      @(negedge clk);
      idle_in();
      tick(2);
      rst = 1'b1;
      tick();
      set_m(0, 2, 32'h400, 0); tick(2);
      set_m(0, 2, 32'h400, 1); tick();
      set_m(0, 0, '0, 0); cbus_addr = 32'h400; set_c(1, 1, 0); tick();
      set_c(1, 1, 1); tick();
      set_c(1, 0, 0); tick(2);
      check("t6_clean_err", 32'(err_o), 0);
      check("t6_clean_outst", 32'(outst_o), 0);

      run = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
